// File: rtl/noc_pkg.sv
// Shared NoC definitions for the partial-sum accumulator: field widths,
// packet type codes, the packet layout and the per-slot state encoding.
package noc_pkg;

  localparam int NOC_SRC_W  = 4;
  localparam int NOC_HOP_W  = 3;
  localparam int NOC_ADDR_W = 27;
  localparam int NOC_DATA_W = 13;
  localparam int NOC_PKT_W  = 2 + 2*NOC_SRC_W + 2 + 2*NOC_HOP_W + NOC_ADDR_W + NOC_DATA_W;

  localparam logic [1:0] PSUM_TYPE = 2'h0;
  localparam logic [1:0] RES_TYPE  = 2'h3;

  // Field order is MSB first, matching the router's flit layout.
  typedef struct packed {
    logic [1:0]            iff_type;
    logic [NOC_SRC_W-1:0]  source;
    logic [NOC_SRC_W-1:0]  dest;
    logic                  x_dir;
    logic [NOC_HOP_W-1:0]  x_hop;
    logic                  y_dir;
    logic [NOC_HOP_W-1:0]  y_hop;
    logic [NOC_ADDR_W-1:0] psum_addr;
    logic [NOC_DATA_W-1:0] data;
  } psum_pkt_t;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_BUSY = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  function automatic logic [NOC_PKT_W-1:0] pkt_pack(input psum_pkt_t p);
    return p;
  endfunction

  function automatic psum_pkt_t pkt_unpack(input logic [NOC_PKT_W-1:0] v);
    return psum_pkt_t'(v);
  endfunction

endpackage

// File: rtl/psum_slot.sv
// One accumulation slot: remembers which output point it is collecting
// (tag), which PEs have contributed (mask), how many (cnt) and the running sum.
module psum_slot
  import noc_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int ACC_W  = 17,
  parameter int NUM_PE = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     accum,
  input  logic                     release_slot,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NUM_PE-1:0]        pe_onehot,
  input  logic signed [ACC_W-1:0]  data_ext,
  output slot_state_e              state,
  output logic [ADDR_W-1:0]        tag,
  output logic [NUM_PE-1:0]        mask,
  output logic signed [ACC_W-1:0]  sum
);

  localparam int CNT_W = $clog2(NUM_PE + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_PE);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  slot_state_e              state_r;
  logic [ADDR_W-1:0]        tag_r;
  logic [NUM_PE-1:0]        mask_r;
  logic [CNT_W-1:0]         cnt_r;
  logic signed [ACC_W-1:0]  sum_r;
  logic [CNT_W-1:0]         cnt_inc_s;

  assign cnt_inc_s = cnt_r + ONE_CNT;

  // Slot lifecycle: release (after emission) wins, then a fresh load, then accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SLOT_FREE;
      tag_r   <= '0;
      mask_r  <= '0;
      cnt_r   <= '0;
      sum_r   <= '0;
    end else if (release_slot) begin
      state_r <= SLOT_FREE;
      mask_r  <= '0;
      cnt_r   <= '0;
      sum_r   <= '0;
    end else if (load) begin
      tag_r   <= addr;
      sum_r   <= data_ext;
      mask_r  <= pe_onehot;
      cnt_r   <= ONE_CNT;
      state_r <= (NUM_PE == 1) ? SLOT_DONE : SLOT_BUSY;
    end else if (accum) begin
      sum_r   <= sum_r + data_ext;
      mask_r  <= mask_r | pe_onehot;
      cnt_r   <= cnt_inc_s;
      state_r <= (cnt_inc_s == FULL_CNT) ? SLOT_DONE : SLOT_BUSY;
    end
  end

  assign state = state_r;
  assign tag   = tag_r;
  assign mask  = mask_r;
  assign sum   = sum_r;

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum reduction engine: collects NUM_PE contributions per output
// point across NUM_SLOTS slots and emits one saturated result packet each.
module psum_accumulator
  import noc_pkg::*;
#(
  parameter int              NUM_PE    = 5,
  parameter int              NUM_SLOTS = 4,
  parameter int              SRC_W     = NOC_SRC_W,
  parameter int              HOP_W     = NOC_HOP_W,
  parameter int              ADDR_W    = NOC_ADDR_W,
  parameter int              DATA_W    = NOC_DATA_W,
  parameter int              SRC_BASE  = 1,
  parameter logic [SRC_W-1:0] OWN_ID   = 4'hD,
  parameter logic [SRC_W-1:0] SINK_ID  = 4'hE,
  parameter int              RELU      = 0,
  parameter int              PKT_W     = 2 + 2*SRC_W + 2 + 2*HOP_W + ADDR_W + DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_packet,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_packet,
  output logic [2:0]       err_pulse
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int ACC_W  = DATA_W + $clog2(NUM_PE) + 1;
  localparam int PE_W   = SRC_W + 1;
  localparam logic [PE_W-1:0]   SRC_BASE_L = PE_W'(SRC_BASE);
  localparam logic [PE_W-1:0]   NUM_PE_L   = PE_W'(NUM_PE);
  localparam logic [NUM_PE-1:0] PE_ONE     = NUM_PE'(1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Input field decode
  logic [1:0]              in_type_s;
  logic [SRC_W-1:0]        in_src_s;
  logic [ADDR_W-1:0]       in_addr_s;
  logic [DATA_W-1:0]       in_data_s;
  logic [SLOT_W-1:0]       slot_idx_s;
  logic [PE_W-1:0]         pe_s;
  logic [NUM_PE-1:0]       pe_onehot_s;
  logic signed [ACC_W-1:0] data_ext_s;
  logic                    bad_type_s;
  logic                    bad_src_s;
  logic                    unused_fields_s;

  assign in_type_s   = in_packet[PKT_W-1 -: 2];
  assign in_src_s    = in_packet[PKT_W-3 -: SRC_W];
  assign in_addr_s   = in_packet[DATA_W +: ADDR_W];
  assign in_data_s   = in_packet[DATA_W-1:0];
  assign slot_idx_s  = in_addr_s[SLOT_W-1:0];
  assign pe_s        = {1'b0, in_src_s} - SRC_BASE_L;
  assign pe_onehot_s = PE_ONE << pe_s;
  assign data_ext_s  = {{(ACC_W-DATA_W){in_data_s[DATA_W-1]}}, in_data_s};
  assign bad_type_s  = (in_type_s != PSUM_TYPE);
  assign bad_src_s   = ({1'b0, in_src_s} < SRC_BASE_L) || (pe_s >= NUM_PE_L);
  // dest and routing fields carry no meaning at the final hop
  assign unused_fields_s = ^in_packet[PKT_W-3-SRC_W : DATA_W+ADDR_W];

  // Slot array
  slot_state_e             state_s [NUM_SLOTS];
  logic [ADDR_W-1:0]       tag_s   [NUM_SLOTS];
  logic [NUM_PE-1:0]       mask_s  [NUM_SLOTS];
  logic signed [ACC_W-1:0] sum_s   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    load_s;
  logic [NUM_SLOTS-1:0]    accum_s;
  logic [NUM_SLOTS-1:0]    release_s;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    psum_slot #(
      .ADDR_W (ADDR_W),
      .ACC_W  (ACC_W),
      .NUM_PE (NUM_PE)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .load         (load_s[g]),
      .accum        (accum_s[g]),
      .release_slot (release_s[g]),
      .addr         (in_addr_s),
      .pe_onehot    (pe_onehot_s),
      .data_ext     (data_ext_s),
      .state        (state_s[g]),
      .tag          (tag_s[g]),
      .mask         (mask_s[g]),
      .sum          (sum_s[g])
    );
  end

  slot_state_e       sel_state_s;
  logic [ADDR_W-1:0] sel_tag_s;
  logic              dup_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [2:0]        err_next_s;

  assign sel_state_s = state_s[slot_idx_s];
  assign sel_tag_s   = tag_s[slot_idx_s];
  assign dup_s       = ((mask_s[slot_idx_s] & pe_onehot_s) != '0);
  assign accept_s    = in_valid && in_ready_s;

  // Backpressure: malformed packets always drain; well-formed ones wait on a DONE or foreign-tag slot.
  always_comb begin
    in_ready_s = 1'b1;
    if (bad_type_s || bad_src_s) begin
      in_ready_s = 1'b1;
    end else if (sel_state_s == SLOT_DONE) begin
      in_ready_s = 1'b0;
    end else if ((sel_state_s == SLOT_BUSY) && (sel_tag_s != in_addr_s)) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = 1'b1;
    end
  end

  // Classify an accepted packet into drop-with-error, slot load or accumulate.
  always_comb begin
    load_s     = '0;
    accum_s    = '0;
    err_next_s = 3'b000;
    if (!accept_s) begin
      err_next_s = 3'b000;
    end else if (bad_type_s) begin
      err_next_s = 3'b001;
    end else if (bad_src_s) begin
      err_next_s = 3'b010;
    end else begin
      case (sel_state_s)
        SLOT_FREE: load_s[slot_idx_s] = 1'b1;
        SLOT_BUSY: begin
          if (dup_s) begin
            err_next_s = 3'b100;
          end else begin
            accum_s[slot_idx_s] = 1'b1;
          end
        end
        default: err_next_s = 3'b000;
      endcase
    end
  end

  // Emission arbitration
  logic                    out_valid_r;
  logic [PKT_W-1:0]        out_packet_r;
  logic [2:0]              err_r;
  logic                    out_free_s;
  logic                    emit_found_s;
  logic [SLOT_W-1:0]       emit_idx_s;
  logic signed [ACC_W-1:0] emit_sum_s;
  logic [DATA_W-1:0]       sat_s;
  logic [DATA_W-1:0]       res_s;

  assign out_free_s = !out_valid_r || out_ready;
  assign emit_sum_s = sum_s[emit_idx_s];

  // Pick the lowest-index DONE slot; scanning downward lets lower indices overwrite.
  always_comb begin
    emit_found_s = 1'b0;
    emit_idx_s   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      emit_found_s = emit_found_s | (state_s[i] == SLOT_DONE);
      emit_idx_s   = (state_s[i] == SLOT_DONE) ? SLOT_W'(i) : emit_idx_s;
    end
  end

  // Free the chosen slot on the same edge its result enters the output register.
  always_comb begin
    release_s = '0;
    if (out_free_s && emit_found_s) begin
      release_s[emit_idx_s] = 1'b1;
    end else begin
      release_s = '0;
    end
  end

  // Clamp the wide sum to the signed data range, then apply the optional ReLU.
  always_comb begin
    sat_s = emit_sum_s[DATA_W-1:0];
    res_s = sat_s;
    if (emit_sum_s > SAT_MAX) begin
      sat_s = SAT_MAX[DATA_W-1:0];
    end else if (emit_sum_s < SAT_MIN) begin
      sat_s = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_s = emit_sum_s[DATA_W-1:0];
    end
    if ((RELU != 0) && sat_s[DATA_W-1]) begin
      res_s = '0;
    end else begin
      res_s = sat_s;
    end
  end

  // Output register: holds while stalled, reloads or empties when free.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_packet_r <= '0;
    end else if (out_free_s) begin
      if (emit_found_s) begin
        out_valid_r  <= 1'b1;
        out_packet_r <= {RES_TYPE, OWN_ID, SINK_ID, 1'b0, {HOP_W{1'b0}},
                         1'b0, {HOP_W{1'b0}}, tag_s[emit_idx_s], res_s};
      end else begin
        out_valid_r  <= 1'b0;
      end
    end
  end

  // Error flags last exactly one cycle after the offending accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 3'b000;
    end else begin
      err_r <= err_next_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_packet = out_packet_r;
  assign err_pulse  = err_r;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: two instances (RELU off/on) share stimulus and
// are compared every cycle against a behavioural model of the slot rules.
module tb_psum_accumulator;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [57:0] in_packet = '0;
  logic        out_ready = 1'b1;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [57:0] out_packet0, out_packet1;
  logic [2:0]  err0, err1;

  always #5 clk = ~clk;

  psum_accumulator #(.RELU(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_packet(in_packet), .out_valid(out_valid0), .out_ready(out_ready),
    .out_packet(out_packet0), .err_pulse(err0));

  psum_accumulator #(.RELU(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_packet(in_packet), .out_valid(out_valid1), .out_ready(out_ready),
    .out_packet(out_packet1), .err_pulse(err1));

  // Reference model: slot state 0=free 1=busy 2=done
  int          m_state [4];
  logic [26:0] m_tag   [4];
  int          m_sum   [4];
  bit   [4:0]  m_seen  [4];
  int          m_cnt   [4];
  bit          m_ov;
  logic [26:0] m_otag;
  int          m_osum;
  logic [2:0]  m_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_acc;
  bit rand_mode = 1'b0;
  logic [26:0] log_addr[$];
  int          log_d0[$];
  int          log_d1[$];
  logic [2:0]  err_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat_val(input int s, input bit relu);
    int v;
    v = (s > 4095) ? 4095 : ((s < -4096) ? -4096 : s);
    if (relu && v < 0) v = 0;
    return v;
  endfunction

  function automatic logic [57:0] mk(input int src, input logic [26:0] addr, input int data,
                                     input logic [1:0] typ);
    psum_pkt_t p;
    p = '0;
    p.iff_type  = typ;
    p.source    = 4'(src);
    p.dest      = 4'($urandom);
    p.x_hop     = 3'($urandom);
    p.y_dir     = 1'($urandom);
    p.psum_addr = addr;
    p.data      = 13'(data);
    return pkt_pack(p);
  endfunction

  function automatic logic [57:0] exp_pkt(input bit relu);
    psum_pkt_t e;
    e = '0;
    e.iff_type  = 2'h3;
    e.source    = 4'hD;
    e.dest      = 4'hE;
    e.psum_addr = m_otag;
    e.data      = 13'(sat_val(m_osum, relu));
    return pkt_pack(e);
  endfunction

  function automatic bit model_ready(input psum_pkt_t p);
    int pe, s;
    pe = int'(p.source) - 1;
    s  = int'(p.psum_addr[1:0]);
    if (p.iff_type != 2'h0 || pe < 0 || pe >= 5) return 1'b1;
    if (m_state[s] == 2) return 1'b0;
    if (m_state[s] == 1 && m_tag[s] != p.psum_addr) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_state[i] = 0; m_sum[i] = 0; m_seen[i] = '0; m_cnt[i] = 0; m_tag[i] = '0;
    end
    m_ov = 1'b0; m_err = 3'b000;
  endtask

  task automatic apply_packet(input psum_pkt_t p);
    int pe, s;
    pe = int'(p.source) - 1;
    s  = int'(p.psum_addr[1:0]);
    if (p.iff_type != 2'h0) m_err = 3'b001;
    else if (pe < 0 || pe >= 5) m_err = 3'b010;
    else if (m_state[s] == 0) begin
      m_tag[s] = p.psum_addr; m_sum[s] = int'($signed(p.data));
      m_seen[s] = 5'(1 << pe); m_cnt[s] = 1; m_state[s] = 1;
    end else if (m_seen[s][pe]) m_err = 3'b100;
    else begin
      m_sum[s] += int'($signed(p.data));
      m_seen[s][pe] = 1'b1;
      m_cnt[s]++;
      if (m_cnt[s] == 5) m_state[s] = 2;
    end
  endtask

  // One clock: compare everything at negedge, then advance the model across posedge.
  task automatic tick();
    psum_pkt_t p;
    bit rdy;
    int j;
    @(negedge clk);
    p   = pkt_unpack(in_packet);
    rdy = model_ready(p);
    check("in_ready", in_ready0, rdy);
    check("in_ready_relu", in_ready1, rdy);
    check("out_valid", out_valid0, m_ov);
    check("out_valid_relu", out_valid1, m_ov);
    if (m_ov) begin
      check("out_packet", out_packet0, exp_pkt(1'b0));
      check("out_packet_relu", out_packet1, exp_pkt(1'b1));
    end
    check("err_pulse", err0, m_err);
    check("err_pulse_relu", err1, m_err);
    err_seen |= err0;
    if (out_valid0 && out_ready) begin
      log_addr.push_back(out_packet0[39:13]);
      log_d0.push_back(int'($signed(out_packet0[12:0])));
      log_d1.push_back(int'($signed(out_packet1[12:0])));
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
      last_acc = 1'b0;
    end else begin
      last_acc = in_valid && rdy;
      m_err = 3'b000;
      if (!m_ov || out_ready) begin
        j = -1;
        for (int i = 3; i >= 0; i--) if (m_state[i] == 2) j = i;
        if (j >= 0) begin
          m_ov = 1'b1; m_otag = m_tag[j]; m_osum = m_sum[j]; m_state[j] = 0;
        end else begin
          m_ov = 1'b0;
        end
      end
      if (last_acc) apply_packet(p);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input int src, input logic [26:0] addr, input int data,
                      input logic [1:0] typ = 2'h0);
    bit ok;
    in_packet = mk(src, addr, data, typ);
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      ok = last_acc;
    end
    check("send_timeout", ok, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_d0.delete(); log_d1.delete(); err_seen = 3'b000;
  endtask

  initial begin
    bit ok;
    int slot;
    logic [26:0] a;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    idle(2);                       // reset state observed under rst
    rst = 1'b0;
    clear_logs();

    // Basic reduction: 5+10+15+20+25
    for (int i = 0; i < 5; i++) send(i + 1, 27'h0, 5 * (i + 1));
    idle(3);
    check("t1_count", log_addr.size(), 1);
    check("t1_addr", log_addr[0], 27'h0);
    check("t1_data", log_d0[0], 75);
    check("t1_no_err", err_seen, 3'b000);
    clear_logs();

    // Interleaved slots 0 and 3
    for (int i = 0; i < 5; i++) begin
      send(i + 1, 27'h0, 1);
      send(i + 1, 27'hF, 8 + 10 * i);
    end
    idle(4);
    check("t2_count", log_addr.size(), 2);
    check("t2_first_addr", log_addr[0], 27'h0);
    check("t2_first_data", log_d0[0], 5);
    check("t2_second_addr", log_addr[1], 27'hF);
    check("t2_second_data", log_d0[1], 140);
    clear_logs();

    // Duplicate source
    send(1, 27'h0, 7); send(2, 27'h0, 100); send(2, 27'h0, 50);
    send(3, 27'h0, 1); send(4, 27'h0, 1); send(5, 27'h0, 1);
    idle(3);
    check("t3_data", log_d0[0], 110);
    check("t3_dup_flag", err_seen, 3'b100);
    clear_logs();

    // Saturation and ReLU
    for (int i = 0; i < 5; i++) send(i + 1, 27'h1, 1000);
    for (int i = 0; i < 5; i++) send(i + 1, 27'h2, -3);
    idle(3);
    check("t4_sat", log_d0[0], 4095);
    check("t4_sat_relu", log_d1[0], 4095);
    check("t4_neg", log_d0[1], -15);
    check("t4_neg_relu", log_d1[1], 0);
    clear_logs();

    // Full stall: out register holds addr 1, slots 0..3 all DONE
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i + 1, 27'h1, 2);
    for (int i = 0; i < 5; i++) send(i + 1, 27'h0, 3);
    for (int i = 0; i < 5; i++) send(i + 1, 27'h2, 4);
    for (int i = 0; i < 5; i++) send(i + 1, 27'h3, 5);
    for (int i = 0; i < 5; i++) send(i + 1, 27'h5, 6);
    send(1, 27'h4, 9, 2'h1);        // malformed packet still drains
    in_packet = mk(1, 27'h4, 9, 2'h0);
    in_valid  = 1'b1;
    idle(4);
    check("t5_stalled", in_ready0, 1'b0);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      ok = last_acc;
    end
    check("t5_accept_after_drain", ok, 1'b1);
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) send(i + 1, 27'h4, 1);
    idle(8);
    check("t5_first_addr", log_addr[0], 27'h1);
    check("t5_second_addr", log_addr[1], 27'h0);
    check("t5_second_data", log_d0[1], 15);
    check("t5_total", log_addr.size(), 6);
    check("t5_bad_type_seen", err_seen, 3'b001);
    clear_logs();

    // Reset mid-accumulation, then malformed packets
    for (int i = 0; i < 3; i++) send(i + 1, 27'h20, 100);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send(i + 1, 27'h20, 2 * (i + 1));
    idle(3);
    check("t6_count", log_addr.size(), 1);
    check("t6_data", log_d0[0], 30);
    send(3, 27'h20, 1, 2'h1);
    send(0, 27'h20, 1);
    idle(2);
    check("t6_err_flags", err_seen, 3'b011);
    clear_logs();

    // Randomised traffic against the model
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      slot = $urandom_range(0, 3);
      a = 27'($urandom);
      a[1:0] = 2'(slot);
      if (m_state[slot] != 0) a = m_tag[slot];
      send(($urandom_range(0, 9) == 0) ? 6 + $urandom_range(0, 9) : $urandom_range(1, 5),
           a, int'($urandom_range(0, 8191)) - 4096,
           ($urandom_range(0, 19) == 0) ? 2'h2 : 2'h0);
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
